// File: rtl/fleet_march_ctrl.sv
// -----------------------------------------------------------------------------
// fleet_march_ctrl
//
// Sequences the enemy fleet's march across the playfield. It decides when the
// fleet steps right, left or down, and it holds the shared x/y offset that every
// ship adds to its start position. It also detects two conditions:
//   - the fleet has landed (y offset reached LAND_Y_P), and
//   - the fleet has been cleared (no live ships), which is followed by a
//     respawn request after RESPAWN_FRAMES_P frames.
//
// Optional feature macro: FLEET_SPEEDUP_EN
//   defined   : step period = max(MIN_PERIOD_P, popcount(alive_i)*PERIOD_PER_SHIP_P),
//               so the fleet speeds up as ships die.
//   undefined : step period is fixed at
//               max(MIN_PERIOD_P, NUM_SHIPS_P*PERIOD_PER_SHIP_P);
//               no population counter is built.
//
// Ports:
//   clk_i        in   1            system clock
//   reset_i      in   1            synchronous, active-high reset
//   frame_i      in   1            one-cycle pulse per displayed frame
//   alive_i      in   NUM_SHIPS_P  bit k high while ship k is alive
//   x_off_o      out  10           fleet horizontal offset (pixels)
//   y_off_o      out  10           fleet vertical offset (pixels)
//   step_x_o     out  1            one-cycle pulse on a horizontal step
//   step_y_o     out  1            one-cycle pulse on a descent step
//   dir_right_o  out  1            current march direction (1 = right)
//   landed_o     out  1            sticky, fleet reached LAND_Y_P
//   respawn_o    out  1            one-cycle respawn request
// -----------------------------------------------------------------------------
module fleet_march_ctrl #(
    parameter int NUM_SHIPS_P       = 8,
    parameter int FLEET_W_P         = 200,
    parameter int SCREEN_W_P        = 640,
    parameter int STEP_X_P          = 10,
    parameter int STEP_Y_P          = 10,
    parameter int LAND_Y_P          = 300,
    parameter int PERIOD_PER_SHIP_P = 6,
    parameter int MIN_PERIOD_P      = 4,
    parameter int RESPAWN_FRAMES_P  = 300
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   frame_i,
    input  logic [NUM_SHIPS_P-1:0] alive_i,
    output logic [9:0]             x_off_o,
    output logic [9:0]             y_off_o,
    output logic                   step_x_o,
    output logic                   step_y_o,
    output logic                   dir_right_o,
    output logic                   landed_o,
    output logic                   respawn_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MARCH_R = 3'd1,
        S_MARCH_L = 3'd2,
        S_DESCEND = 3'd3,
        S_LANDED  = 3'd4,
        S_CLEARED = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Step period
    // ------------------------------------------------------------------
    logic [15:0] w_period;

`ifdef FLEET_SPEEDUP_EN
    // Population count built as a running prefix sum over the ships.
    logic [15:0] w_psum [0:NUM_SHIPS_P];
    logic [15:0] w_raw_period;

    assign w_psum[0] = 16'd0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SHIPS_P; gi++) begin : g_popcnt
            assign w_psum[gi+1] = w_psum[gi] + {15'd0, alive_i[gi]};
        end
    endgenerate

    assign w_raw_period = w_psum[NUM_SHIPS_P] * 16'(PERIOD_PER_SHIP_P);
    assign w_period     = (w_raw_period < 16'(MIN_PERIOD_P)) ? 16'(MIN_PERIOD_P)
                                                             : w_raw_period;
`else
    localparam int FIXED_PERIOD_L =
        (NUM_SHIPS_P * PERIOD_PER_SHIP_P < MIN_PERIOD_P) ? MIN_PERIOD_P
                                                         : NUM_SHIPS_P * PERIOD_PER_SHIP_P;
    assign w_period = 16'(FIXED_PERIOD_L);
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_resp_cnt;
    logic [9:0]  r_x_off;
    logic [9:0]  r_y_off;
    logic        r_dir_right;
    logic        r_step_x;
    logic        r_step_y;
    logic        r_landed;
    logic        r_respawn;

    state_t      w_state_next;
    logic [15:0] w_frame_cnt_next;
    logic [15:0] w_resp_cnt_next;
    logic [9:0]  w_x_off_next;
    logic [9:0]  w_y_off_next;
    logic        w_dir_right_next;
    logic        w_step_x_next;
    logic        w_step_y_next;
    logic        w_landed_next;
    logic        w_respawn_next;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic        w_cleared;
    logic        w_period_hit;
    logic [11:0] w_right_edge;
    logic        w_fits_right;
    logic        w_fits_left;
    logic [9:0]  w_y_step;
    logic        w_lands;

    assign w_cleared    = (alive_i == '0);
    // ">=" rather than "==" so a period that shrank below the current count
    // still fires on the very next frame instead of wrapping.
    assign w_period_hit = ((r_frame_cnt + 16'd1) >= w_period);
    assign w_right_edge = {2'b00, r_x_off} + 12'(FLEET_W_P + STEP_X_P);
    assign w_fits_right = (w_right_edge <= 12'(SCREEN_W_P));
    assign w_fits_left  = (r_x_off >= 10'(STEP_X_P));
    assign w_y_step     = r_y_off + 10'(STEP_Y_P);
    assign w_lands      = (w_y_step >= 10'(LAND_Y_P));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 16'd0;
            r_resp_cnt  <= 16'd0;
            r_x_off     <= 10'd0;
            r_y_off     <= 10'd0;
            r_dir_right <= 1'b1;
            r_step_x    <= 1'b0;
            r_step_y    <= 1'b0;
            r_landed    <= 1'b0;
            r_respawn   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_resp_cnt  <= w_resp_cnt_next;
            r_x_off     <= w_x_off_next;
            r_y_off     <= w_y_off_next;
            r_dir_right <= w_dir_right_next;
            r_step_x    <= w_step_x_next;
            r_step_y    <= w_step_y_next;
            r_landed    <= w_landed_next;
            r_respawn   <= w_respawn_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_frame_cnt_next = r_frame_cnt;
        w_resp_cnt_next  = r_resp_cnt;
        w_x_off_next     = r_x_off;
        w_y_off_next     = r_y_off;
        w_dir_right_next = r_dir_right;
        w_step_x_next    = 1'b0;
        w_step_y_next    = 1'b0;
        w_landed_next    = r_landed;
        w_respawn_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_i) begin
                    w_state_next     = S_MARCH_R;
                    w_frame_cnt_next = 16'd0;
                end
            end

            S_MARCH_R, S_MARCH_L: begin
                if (w_cleared) begin
                    w_state_next    = S_CLEARED;
                    w_resp_cnt_next = 16'd0;
                end else if (frame_i) begin
                    if (w_period_hit) begin
                        w_frame_cnt_next = 16'd0;
                        if (r_state == S_MARCH_R) begin
                            if (w_fits_right) begin
                                w_x_off_next  = r_x_off + 10'(STEP_X_P);
                                w_step_x_next = 1'b1;
                            end else begin
                                // Direction flips on entry to DESCEND so the
                                // descent frame already shows the new heading.
                                w_state_next     = S_DESCEND;
                                w_dir_right_next = 1'b0;
                            end
                        end else begin
                            if (w_fits_left) begin
                                w_x_off_next  = r_x_off - 10'(STEP_X_P);
                                w_step_x_next = 1'b1;
                            end else begin
                                w_state_next     = S_DESCEND;
                                w_dir_right_next = 1'b1;
                            end
                        end
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + 16'd1;
                    end
                end
            end

            S_DESCEND: begin
                if (w_cleared) begin
                    w_state_next    = S_CLEARED;
                    w_resp_cnt_next = 16'd0;
                end else if (frame_i) begin
                    w_y_off_next     = w_y_step;
                    w_step_y_next    = 1'b1;
                    w_frame_cnt_next = 16'd0;
                    if (w_lands) begin
                        w_state_next  = S_LANDED;
                        w_landed_next = 1'b1;
                    end else begin
                        w_state_next = r_dir_right ? S_MARCH_R : S_MARCH_L;
                    end
                end
            end

            S_LANDED: begin
                // Terminal until reset; everything stays frozen.
            end

            S_CLEARED: begin
                if (frame_i) begin
                    if (r_resp_cnt == 16'(RESPAWN_FRAMES_P - 1)) begin
                        w_respawn_next   = 1'b1;
                        w_x_off_next     = 10'd0;
                        w_y_off_next     = 10'd0;
                        w_dir_right_next = 1'b1;
                        w_resp_cnt_next  = 16'd0;
                        w_frame_cnt_next = 16'd0;
                        w_state_next     = S_IDLE;
                    end else begin
                        w_resp_cnt_next = r_resp_cnt + 16'd1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign x_off_o     = r_x_off;
    assign y_off_o     = r_y_off;
    assign step_x_o    = r_step_x;
    assign step_y_o    = r_step_y;
    assign dir_right_o = r_dir_right;
    assign landed_o    = r_landed;
    assign respawn_o   = r_respawn;

endmodule

// File: tb/tb_fleet_march_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fleet_march_ctrl
//
// Two instances share one clock:
//   dut1 - default parameters; exercises the march, the period change with
//          a reduced fleet, clear/respawn and reset in the middle of a count.
//   dut2 - fleet as wide as the screen, so every horizontal step attempt turns
//          into a descent; this reaches the landing line quickly.
// -----------------------------------------------------------------------------
module tb_fleet_march_ctrl;

`ifdef FLEET_SPEEDUP_EN
    localparam bit SPD = 1'b1;
`else
    localparam bit SPD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut1 signals
    logic       rst1, fr1;
    logic [7:0] alive1;
    logic [9:0] x1, y1;
    logic       sx1_o, sy1_o, dir1, land1, rsp1;

    // dut2 signals
    logic       rst2, fr2;
    logic [7:0] alive2;
    logic [9:0] x2, y2;
    logic       sx2_o, sy2_o, dir2, land2, rsp2;

    fleet_march_ctrl dut1 (
        .clk_i      (clk),
        .reset_i    (rst1),
        .frame_i    (fr1),
        .alive_i    (alive1),
        .x_off_o    (x1),
        .y_off_o    (y1),
        .step_x_o   (sx1_o),
        .step_y_o   (sy1_o),
        .dir_right_o(dir1),
        .landed_o   (land1),
        .respawn_o  (rsp1)
    );

    fleet_march_ctrl #(
        .FLEET_W_P        (640),
        .PERIOD_PER_SHIP_P(1)
    ) dut2 (
        .clk_i      (clk),
        .reset_i    (rst2),
        .frame_i    (fr2),
        .alive_i    (alive2),
        .x_off_o    (x2),
        .y_off_o    (y2),
        .step_x_o   (sx2_o),
        .step_y_o   (sy2_o),
        .dir_right_o(dir2),
        .landed_o   (land2),
        .respawn_o  (rsp2)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Pulse counters, sampled on the falling edge.
    int sx1 = 0, sy1 = 0, rs1 = 0;
    int sx2 = 0, sy2 = 0, rs2 = 0;

    always @(negedge clk) begin
        if (sx1_o) sx1++;
        if (sy1_o) sy1++;
        if (rsp1)  rs1++;
        if (sx2_o) sx2++;
        if (sy2_o) sy2++;
        if (rsp2)  rs2++;
        if (sx1_o || sy1_o || rsp1) begin
            n_total++;
            if (int'(sx1_o) + int'(sy1_o) + int'(rsp1) > 1) begin
                n_bad++;
                $display("FAIL pulse_excl1: got sx=%0d sy=%0d rs=%0d want at most one", sx1_o, sy1_o, rsp1);
            end
        end
        if (sx2_o || sy2_o || rsp2) begin
            n_total++;
            if (int'(sx2_o) + int'(sy2_o) + int'(rsp2) > 1) begin
                n_bad++;
                $display("FAIL pulse_excl2: got sx=%0d sy=%0d rs=%0d want at most one", sx2_o, sy2_o, rsp2);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // n frame pulses, one every 4 clocks, to the selected instance.
    task automatic frames(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (which == 1) fr1 = 1'b1; else fr2 = 1'b1;
            @(posedge clk); #1;
            fr1 = 1'b0;
            fr2 = 1'b0;
            @(posedge clk);
            @(posedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] alive;
        int         nfr;
        int         ex;
        int         ey;
        int         edir;
        int         eland;
        int         dsx;
        int         dsy;
        int         drs;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    initial begin
        int b_sx, b_sy, b_rs;

        // Expected values that depend on whether the period tracks alive_i.
        int x7, x8, x9, s7, s8, s9;
        x7 = SPD ? 420 : 430;  s7 = SPD ? 1 : 0;
        x8 = SPD ? 410 : 430;  s8 = SPD ? 1 : 0;
        x9 = SPD ? 350 : 420;  s9 = SPD ? 6 : 1;

        //          alive   frames x    y   dir land dsx dsy drs
        vt[0]  = '{8'hFF,    1,    0,   0, 1, 0,  0, 0, 0}; // enter MARCH_R
        vt[1]  = '{8'hFF,   47,    0,   0, 1, 0,  0, 0, 0}; // 47 counted, no step
        vt[2]  = '{8'hFF,    1,   10,   0, 1, 0,  1, 0, 0}; // 49th frame: first step
        vt[3]  = '{8'hFF, 2064,  440,   0, 1, 0, 43, 0, 0}; // march to right edge
        vt[4]  = '{8'hFF,   48,  440,   0, 0, 0,  0, 0, 0}; // blocked: enter DESCEND
        vt[5]  = '{8'hFF,    1,  440,  10, 0, 0,  0, 1, 0}; // descent
        vt[6]  = '{8'hFF,   48,  430,  10, 0, 0,  1, 0, 0}; // march left
        vt[7]  = '{8'h01,    6,   x7,  10, 0, 0, s7, 0, 0}; // one ship left
        vt[8]  = '{8'h01,    6,   x8,  10, 0, 0, s8, 0, 0};
        vt[9]  = '{8'h01,   36,   x9,  10, 0, 0, s9, 0, 0};
        vt[10] = '{8'h00,  299,   x9,  10, 0, 0,  0, 0, 0}; // cleared, counting
        vt[11] = '{8'h00,    1,    0,   0, 1, 0,  0, 0, 1}; // 300th frame: respawn
        vt[12] = '{8'hFF,    1,    0,   0, 1, 0,  0, 0, 0}; // IDLE -> MARCH_R
        vt[13] = '{8'hFF,   48,   10,   0, 1, 0,  1, 0, 0}; // full period again

        rst1 = 1'b1; rst2 = 1'b1;
        fr1  = 1'b0; fr2  = 1'b0;
        alive1 = 8'hFF; alive2 = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst.x",       int'(x1),    0);
        check("rst.y",       int'(y1),    0);
        check("rst.dir",     int'(dir1),  1);
        check("rst.landed",  int'(land1), 0);
        check("rst.step_x",  int'(sx1_o), 0);
        check("rst.step_y",  int'(sy1_o), 0);
        check("rst.respawn", int'(rsp1),  0);
        check("rst2.landed", int'(land2), 0);
        $display("reset x=%0d y=%0d dir=%0d landed=%0d", x1, y1, dir1, land1);

        // Table-driven march on dut1
        for (int i = 0; i < NV; i++) begin
            alive1 = vt[i].alive;
            b_sx = sx1; b_sy = sy1; b_rs = rs1;
            frames(1, vt[i].nfr);
            @(negedge clk);
            check($sformatf("v%0d.x", i),       int'(x1),    vt[i].ex);
            check($sformatf("v%0d.y", i),       int'(y1),    vt[i].ey);
            check($sformatf("v%0d.dir", i),     int'(dir1),  vt[i].edir);
            check($sformatf("v%0d.landed", i),  int'(land1), vt[i].eland);
            check($sformatf("v%0d.step_x", i),  sx1 - b_sx,  vt[i].dsx);
            check($sformatf("v%0d.step_y", i),  sy1 - b_sy,  vt[i].dsy);
            check($sformatf("v%0d.respawn", i), rs1 - b_rs,  vt[i].drs);
            $display("vec %0d alive=%h frames=%0d x=%0d y=%0d dir=%0d sx=%0d sy=%0d rs=%0d",
                     i, vt[i].alive, vt[i].nfr, x1, y1, dir1, sx1 - b_sx, sy1 - b_sy, rs1 - b_rs);
        end

        // Reset in the middle of a period count discards the count.
        frames(1, 20);
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        check("midrst.x",      int'(x1),    0);
        check("midrst.y",      int'(y1),    0);
        check("midrst.dir",    int'(dir1),  1);
        check("midrst.landed", int'(land1), 0);
        rst1 = 1'b0;
        b_sx = sx1;
        frames(1, 48);
        @(negedge clk);
        check("midrst.nostep", sx1 - b_sx, 0);
        frames(1, 1);
        @(negedge clk);
        check("midrst.step", sx1 - b_sx, 1);
        check("midrst.x2",   int'(x1),   10);
        $display("midrst x=%0d steps=%0d", x1, sx1 - b_sx);

        // Landing on dut2: each descent costs 8 blocked frames plus 1 drop.
        frames(2, 1);
        for (int d = 1; d <= 30; d++) begin
            frames(2, 8);
            frames(2, 1);
            if (d == 29) begin
                @(negedge clk);
                check("land.y29",      int'(y2),    290);
                check("land.landed29", int'(land2), 0);
            end
        end
        @(negedge clk);
        check("land.y",      int'(y2),    300);
        check("land.landed", int'(land2), 1);
        check("land.sy",     sy2,         30);
        check("land.sx",     sx2,         0);
        $display("landing y=%0d landed=%0d descents=%0d", y2, land2, sy2);

        b_sx = sx2; b_sy = sy2;
        frames(2, 20);
        @(negedge clk);
        check("frozen.landed", int'(land2), 1);
        check("frozen.y",      int'(y2),    300);
        check("frozen.pulses", (sx2 - b_sx) + (sy2 - b_sy) + rs2, 0);
        $display("frozen y=%0d landed=%0d extra_pulses=%0d", y2, land2, (sx2 - b_sx) + (sy2 - b_sy));

        // Reset while LANDED
        rst2 = 1'b1;
        @(negedge clk);
        check("lrst.landed", int'(land2), 0);
        check("lrst.y",      int'(y2),    0);
        check("lrst.x",      int'(x2),    0);
        check("lrst.dir",    int'(dir2),  1);
        rst2 = 1'b0;
        $display("landed reset x=%0d y=%0d landed=%0d", x2, y2, land2);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
